control_teclado_temp: RTL and testbench

Keypad-entry controller that sequences the temperature monitor datapath. It accepts decoded key strobes from the keypad scanner and assembles one or two decimal digits into a temperature value. On the enter key it range-checks the value, loads the 5-bit temperature register feeding the comparators and alarm/fan FSM, raises the monitor enable, and issues a one-cycle read strobe. It sits between the keypad decoder and the temperature monitor top level.

---
 rtl/control_teclado_temp_pkg.sv | 22 ++
 rtl/contador_timeout.sv | 43 ++++
 rtl/control_teclado_temp.sv | 137 +++++++++++++
 tb/tb_control_teclado_temp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_teclado_temp_pkg.sv
// Shared key codes, state encoding and defaults for the keypad temperature controller.
package control_teclado_temp_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    localparam int unsigned TEMP_MAX_DEFAULT = 31;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StD1   = 3'd1,
        StD2   = 3'd2,
        StLoad = 3'd3,
        StErr  = 3'd4
    } state_e;

    // Decimal digit keys are 0x0-0x9
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Down-counter that measures idle cycles between keys of one entry.
module contador_timeout #(
    parameter int unsigned TIMEOUT = 8,
    localparam int unsigned Width  = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clr,
    input  logic dec,
    output logic expire
);

    localparam logic [Width-1:0] LoadVal = Width'(TIMEOUT);
    localparam logic [Width-1:0] One     = Width'(1);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: reload on an accepted key, otherwise count idle cycles down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadVal;
        end else if (clr) begin
            cnt_d = '0;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - One;
        end
    end

    // Counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle that would take the count from 1 to 0 is the TIMEOUT-th idle cycle
    assign expire = dec && (cnt_q == One);

endmodule

// File: rtl/control_teclado_temp.sv
// Keypad entry controller: assembles up to two digits, range-checks on enter and
// loads the temperature register feeding the monitor datapath.
module control_teclado_temp
    import control_teclado_temp_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 100_000_000,
    parameter int unsigned TEMP_MAX = TEMP_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [4:0] temperatura,
    output logic       en_m1,
    output logic       lect,
    output logic       busy,
    output logic       error
);

    localparam logic [6:0] TempMaxAcc = 7'(TEMP_MAX);

    state_e     state_q, state_d;
    logic [6:0] acc_q, acc_d;
    logic [4:0] temp_q, temp_d;
    logic       en_q, en_d;

    logic       key_ok;
    logic       key_digit;
    logic       key_enter;
    logic [6:0] acc_mac;
    logic       in_entry;
    logic       cnt_load, cnt_clr, cnt_dec, cnt_expire;

    // Codes 0xC-0xF never count as a key, so they neither act nor restart the timeout
    assign key_ok    = key_valid && (key_code <= KEY_CLEAR);
    assign key_digit = is_digit(key_code);
    assign key_enter = (key_code == KEY_ENTER);
    assign acc_mac   = (acc_q << 3) + (acc_q << 1) + {3'b000, key_code};
    assign in_entry  = (state_q == StD1) || (state_q == StD2);

    // Next-state, accumulator and output register logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        temp_d  = temp_q;
        en_d    = en_q;
        case (state_q)
            StIdle: begin
                if (key_ok && key_digit) begin
                    acc_d   = {3'b000, key_code};
                    state_d = StD1;
                end
            end
            StD1, StD2: begin
                if (key_ok) begin
                    if (key_digit) begin
                        if (state_q == StD1) begin
                            acc_d   = acc_mac;
                            state_d = StD2;
                        end else begin
                            state_d = StErr;
                        end
                    end else if (key_enter) begin
                        if (acc_q <= TempMaxAcc) begin
                            temp_d  = acc_q[4:0];
                            en_d    = 1'b1;
                            state_d = StLoad;
                        end else begin
                            state_d = StErr;
                        end
                    end else begin
                        acc_d   = '0;
                        state_d = StIdle;
                    end
                end else if (cnt_expire) begin
                    // Key wins over expiry because this branch is only reached without one
                    acc_d   = '0;
                    state_d = StIdle;
                end
            end
            StLoad: begin
                acc_d   = '0;
                state_d = StIdle;
            end
            StErr: begin
                if (key_ok && (key_code == KEY_CLEAR)) begin
                    acc_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Timeout control: restart on accepted keys that keep the entry alive
    always_comb begin
        cnt_load = key_ok && ((state_d == StD1) || (state_d == StD2));
        cnt_clr  = !((state_d == StD1) || (state_d == StD2));
        cnt_dec  = in_entry && !key_ok;
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            temp_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            temp_q  <= temp_d;
            en_q    <= en_d;
        end
    end

    contador_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .clr   (cnt_clr),
        .dec   (cnt_dec),
        .expire(cnt_expire)
    );

    assign temperatura = temp_q;
    assign en_m1       = en_q;
    assign lect        = (state_q == StLoad);
    assign busy        = in_entry || (state_q == StLoad);
    assign error       = (state_q == StErr);

endmodule

// File: tb/tb_control_teclado_temp.sv
// Directed self-checking bench for the keypad temperature controller.
module tb_control_teclado_temp;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [4:0] temperatura;
    logic       en_m1;
    logic       lect;
    logic       busy;
    logic       error;

    int checks = 0;
    int errors = 0;

    control_teclado_temp #(
        .TIMEOUT (8),
        .TEMP_MAX(31)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .temperatura(temperatura),
        .en_m1      (en_m1),
        .lect       (lect),
        .busy       (busy),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle key strobe; returns 1 time unit after the sampling edge
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_temp", 32'(temperatura), 0);
        check("rst_en", 32'(en_m1), 0);
        check("rst_lect", 32'(lect), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(error), 0);
        reset = 1'b0;
        idle(1);

        // 2,7,enter -> 27
        press(4'h2);
        check("d1_busy", 32'(busy), 1);
        press(4'h7);
        check("pre_en", 32'(en_m1), 0);
        press(4'hA);
        check("t27_temp", 32'(temperatura), 27);
        check("t27_lect", 32'(lect), 1);
        check("t27_en", 32'(en_m1), 1);
        check("t27_busy", 32'(busy), 1);
        idle(1);
        check("t27_lect_off", 32'(lect), 0);
        check("t27_busy_off", 32'(busy), 0);

        // 3,5,enter -> out of range
        press(4'h3);
        press(4'h5);
        press(4'hA);
        check("t35_err", 32'(error), 1);
        check("t35_lect", 32'(lect), 0);
        check("t35_temp", 32'(temperatura), 27);
        check("t35_en", 32'(en_m1), 1);
        press(4'hB);
        check("t35_clr_err", 32'(error), 0);
        check("t35_clr_busy", 32'(busy), 0);

        // 1,2,3 -> third digit error; enter ignored; clear; 9,enter
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check("t123_err", 32'(error), 1);
        press(4'hA);
        check("t123_ent_err", 32'(error), 1);
        check("t123_ent_lect", 32'(lect), 0);
        press(4'hB);
        check("t123_clr", 32'(error), 0);
        press(4'h9);
        press(4'hA);
        check("t9_temp", 32'(temperatura), 9);
        check("t9_lect", 32'(lect), 1);
        idle(1);

        // Timeout: 8 idle cycles abandon the entry
        press(4'h2);
        idle(7);
        check("to7_busy", 32'(busy), 1);
        idle(1);
        check("to8_busy", 32'(busy), 0);
        press(4'h5);
        press(4'hA);
        check("to_temp", 32'(temperatura), 5);
        idle(1);

        // Key at idle cycle 7 restarts the counter
        press(4'h2);
        idle(6);
        press(4'h5);
        idle(7);
        check("alive_busy", 32'(busy), 1);
        press(4'hA);
        check("alive_temp", 32'(temperatura), 25);
        idle(1);

        // Key on the expiry cycle wins
        press(4'h1);
        idle(7);
        press(4'h2);
        press(4'hA);
        check("tie_temp", 32'(temperatura), 12);
        idle(1);

        // Ignored code does not restart the timeout
        press(4'h4);
        idle(3);
        press(4'hE);
        idle(3);
        check("ign_busy", 32'(busy), 1);
        idle(1);
        check("ign_expired", 32'(busy), 0);

        // Ignored code and enter in IDLE
        press(4'hE);
        check("idle_e_busy", 32'(busy), 0);
        press(4'hA);
        check("idle_ent_lect", 32'(lect), 0);
        check("idle_ent_busy", 32'(busy), 0);
        check("idle_ent_temp", 32'(temperatura), 12);

        // Back-to-back strobes: 3,1,enter -> 31 (upper bound)
        press(4'h3);
        press(4'h1);
        press(4'hA);
        check("t31_temp", 32'(temperatura), 31);
        check("t31_lect", 32'(lect), 1);
        idle(1);

        // 32 is just above the limit
        press(4'h3);
        press(4'h2);
        press(4'hA);
        check("t32_err", 32'(error), 1);
        check("t32_temp", 32'(temperatura), 31);
        press(4'hB);

        // Asynchronous reset mid-entry
        press(4'h2);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_temp", 32'(temperatura), 0);
        check("mid_rst_en", 32'(en_m1), 0);
        check("mid_rst_lect", 32'(lect), 0);
        check("mid_rst_err", 32'(error), 0);
        idle(2);
        reset = 1'b0;
        idle(1);
        press(4'h8);
        press(4'hA);
        check("t8_temp", 32'(temperatura), 8);
        check("t8_en", 32'(en_m1), 1);
        check("t8_lect", 32'(lect), 1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
